// File: rtl/my_pkg.sv
// Shared bus widths and the request/response payload type.
package my_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 16;

  // For requests ready is the op flag (1 = write); for responses it is the status (1 = OK).
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  valid;
    logic                  ready;
  } bus_transaction_t;

endpackage

// File: rtl/bus_txn_responder.sv
// Single-outstanding bus responder in front of a small register file.
// Flow: IDLE captures a request, ACCESS decodes it and touches the register
// file for one cycle, RESP holds the response until the initiator takes it.
module bus_txn_responder
  import my_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned TXN_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  bus_transaction_t      req_in,
  output logic                  req_accept,
  output bus_transaction_t      rsp_out,
  input  logic                  rsp_taken,
  output logic [TXN_CNT_W-1:0]  txn_count
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  req_data;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   req_wr;
  logic [DATA_WIDTH-1:0]  regs [NUM_REGS];

  logic [IDX_W-1:0]       idx;
  logic                   hit;

  // Decode of the captured request: low bits index, any higher bit set is a miss.
  assign idx = req_addr[IDX_W-1:0];
  assign hit = (req_addr >> IDX_W) == '0;

  // Transaction FSM, register file and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_data   <= '0;
      req_addr   <= '0;
      req_wr     <= 1'b0;
      req_accept <= 1'b0;
      rsp_out    <= '0;
      txn_count  <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      req_accept <= 1'b0;
      case (state)
        IDLE: begin
          if (req_in.valid) begin
            req_data   <= req_in.data;
            req_addr   <= req_in.addr;
            req_wr     <= req_in.ready;
            req_accept <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // Writes return the written data directly, so no read-after-write hazard exists.
          if (hit && req_wr) begin
            regs[idx] <= req_data;
          end
          if (!hit) begin
            rsp_out.data <= '0;
          end else if (req_wr) begin
            rsp_out.data <= req_data;
          end else begin
            rsp_out.data <= regs[idx];
          end
          rsp_out.addr  <= req_addr;
          rsp_out.valid <= 1'b1;
          rsp_out.ready <= hit;
          state         <= RESP;
        end
        RESP: begin
          if (rsp_taken) begin
            rsp_out.valid <= 1'b0;
            txn_count     <= txn_count + TXN_CNT_W'(1);
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_txn_responder.sv
// Randomized self-checking bench for bus_txn_responder against a behavioural model.
module tb_bus_txn_responder;
  import my_pkg::*;

  localparam int NREGS = 16;

  logic             clk;
  logic             rst_n;
  bus_transaction_t req_in;
  logic             req_accept;
  bus_transaction_t rsp_out;
  logic             rsp_taken;
  logic [7:0]       txn_count;

  int total;
  int bad;

  // Behavioural model: register array and completion count.
  logic [31:0] mregs [NREGS];
  int          mcnt;

  bus_txn_responder #(.NUM_REGS(16), .TXN_CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .req_accept (req_accept),
    .rsp_out    (rsp_out),
    .rsp_taken  (rsp_taken),
    .txn_count  (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of one transaction; returns the response the initiator should see.
  task automatic model_txn(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                           output bus_transaction_t exp);
    exp = '0;
    exp.addr  = addr;
    exp.valid = 1'b1;
    if (int'(addr) < NREGS) begin
      exp.ready = 1'b1;
      if (wr) begin
        mregs[int'(addr)] = data;
        exp.data = data;
      end else begin
        exp.data = mregs[int'(addr)];
      end
    end
    mcnt = (mcnt + 1) % 256;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) mregs[i] = '0;
    mcnt = 0;
  endtask

  // Runs one transaction from IDLE; caller must be just after a rising edge.
  // Observations are returned for the caller to compare.
  task automatic xact(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                      input int stall, input logic hold_valid,
                      output logic acc, output bus_transaction_t rsp,
                      output logic stable, output logic valid_after, output logic [7:0] cnt_after);
    req_in.data  = data;
    req_in.addr  = addr;
    req_in.valid = 1'b1;
    req_in.ready = wr;
    rsp_taken    = 1'b0;
    @(posedge clk); #1;
    acc = req_accept;
    // Scramble the request after capture; valid stays up only when asked.
    req_in.data  = $urandom;
    req_in.addr  = 16'($urandom);
    req_in.ready = 1'($urandom);
    req_in.valid = hold_valid;
    @(posedge clk); #1;
    rsp = rsp_out;
    stable = 1'b1;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      if (rsp_out !== rsp || req_accept !== 1'b0) stable = 1'b0;
    end
    req_in.valid = 1'b0;
    rsp_taken    = 1'b1;
    @(posedge clk); #1;
    rsp_taken   = 1'b0;
    valid_after = rsp_out.valid;
    cnt_after   = txn_count;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_in = '0;
    rsp_taken = 1'b0;
    model_reset();
    #1;
    total++;
    if (req_accept !== 1'b0 || rsp_out !== '0 || txn_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: acc=%b rsp=%h cnt=%0d want 0/0/0", req_accept, rsp_out, txn_count);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    bus_transaction_t rsp, exp;
    logic acc, st, va;
    logic [7:0] cnt;
    xact(1'b1, 16'h0003, 32'hDEADBEEF, 0, 1'b0, acc, rsp, st, va, cnt);
    model_txn(1'b1, 16'h0003, 32'hDEADBEEF, exp);
    total++;
    if (acc !== 1'b1 || rsp !== exp) begin
      bad++;
      $display("FAIL wr_3: acc=%b rsp=%h want acc=1 rsp=%h", acc, rsp, exp);
    end
    xact(1'b0, 16'h0003, 32'h0, 0, 1'b0, acc, rsp, st, va, cnt);
    model_txn(1'b0, 16'h0003, 32'h0, exp);
    total++;
    if (rsp !== exp || rsp.data !== 32'hDEADBEEF || rsp.ready !== 1'b1) begin
      bad++;
      $display("FAIL rd_3: rsp=%h want %h", rsp, exp);
    end
    total++;
    if (cnt !== 8'd2 || va !== 1'b0) begin
      bad++;
      $display("FAIL wr_rd_count: cnt=%0d valid=%b want 2/0", cnt, va);
    end
  endtask

  task automatic test_miss();
    bus_transaction_t rsp, exp;
    logic acc, st, va;
    logic [7:0] cnt;
    xact(1'b1, 16'h0010, 32'h0000_1234, 0, 1'b0, acc, rsp, st, va, cnt);
    model_txn(1'b1, 16'h0010, 32'h0000_1234, exp);
    total++;
    if (rsp !== exp || rsp.ready !== 1'b0 || rsp.data !== 32'h0) begin
      bad++;
      $display("FAIL miss_wr: rsp=%h want %h", rsp, exp);
    end
    xact(1'b0, 16'h0000, 32'h0, 0, 1'b0, acc, rsp, st, va, cnt);
    model_txn(1'b0, 16'h0000, 32'h0, exp);
    total++;
    if (rsp !== exp || rsp.data !== 32'h0) begin
      bad++;
      $display("FAIL miss_rd0: rsp=%h want %h", rsp, exp);
    end
  endtask

  task automatic test_random();
    bus_transaction_t rsp, exp;
    logic acc, st, va, wr;
    logic [7:0] cnt;
    logic [15:0] a;
    logic [31:0] d;
    int stall;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom);
      a  = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, NREGS - 1))
                                       : 16'($urandom_range(NREGS, 65535));
      d  = $urandom;
      stall = $urandom_range(0, 3);
      xact(wr, a, d, stall, 1'($urandom), acc, rsp, st, va, cnt);
      model_txn(wr, a, d, exp);
      total++;
      if (acc !== 1'b1 || rsp !== exp || st !== 1'b1 || va !== 1'b0 || cnt !== 8'(mcnt)) begin
        bad++;
        $display("FAIL rand_%0d: acc=%b rsp=%h st=%b va=%b cnt=%0d want 1 %h 1 0 %0d",
                 n, acc, rsp, st, va, cnt, exp, mcnt);
      end
    end
  endtask

  task automatic test_backpressure();
    bus_transaction_t rsp, exp;
    logic acc, st, va;
    logic [7:0] cnt;
    logic [31:0] d;
    d = $urandom;
    xact(1'b1, 16'h0007, d, 10, 1'b1, acc, rsp, st, va, cnt);
    model_txn(1'b1, 16'h0007, d, exp);
    total++;
    if (rsp !== exp || st !== 1'b1) begin
      bad++;
      $display("FAIL backpressure_hold: rsp=%h stable=%b want %h 1", rsp, st, exp);
    end
    total++;
    if (cnt !== 8'(mcnt) || va !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_done: cnt=%0d valid=%b want %0d 0", cnt, va, mcnt);
    end
    // Idle cycles afterwards: no extra completion.
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (txn_count !== 8'(mcnt) || rsp_out.valid !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_single: cnt=%0d valid=%b want %0d 0", txn_count, rsp_out.valid, mcnt);
    end
  endtask

  task automatic test_ignore_taken();
    rsp_taken = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rsp_taken = 1'b0;
    total++;
    if (txn_count !== 8'(mcnt) || rsp_out.valid !== 1'b0 || req_accept !== 1'b0) begin
      bad++;
      $display("FAIL taken_in_idle: cnt=%0d valid=%b acc=%b want %0d 0 0",
               txn_count, rsp_out.valid, req_accept, mcnt);
    end
  endtask

  task automatic test_throughput();
    bus_transaction_t exp;
    logic [31:0] d;
    logic [15:0] a;
    logic acc_e, val_e;
    d = $urandom;
    a = 16'($urandom_range(0, NREGS - 1));
    req_in.data  = d;
    req_in.addr  = a;
    req_in.ready = 1'b1;
    req_in.valid = 1'b1;
    rsp_taken    = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      acc_e = (k % 3 == 1);
      val_e = (k % 3 == 2);
      if (acc_e) model_txn(1'b1, a, d, exp);
      total++;
      if (req_accept !== acc_e || rsp_out.valid !== val_e) begin
        bad++;
        $display("FAIL throughput_edge%0d: acc=%b valid=%b want %b %b", k, req_accept, rsp_out.valid, acc_e, val_e);
      end
      if (val_e) begin
        total++;
        if (rsp_out !== exp) begin
          bad++;
          $display("FAIL throughput_rsp%0d: rsp=%h want %h", k, rsp_out, exp);
        end
      end
    end
    req_in.valid = 1'b0;
    rsp_taken    = 1'b0;
    total++;
    if (txn_count !== 8'(mcnt)) begin
      bad++;
      $display("FAIL throughput_count: cnt=%0d want %0d", txn_count, mcnt);
    end
  endtask

  task automatic test_reset_mid();
    bus_transaction_t rsp, exp;
    logic acc, st, va;
    logic [7:0] cnt;
    req_in.data  = 32'hA5A5A5A5;
    req_in.addr  = 16'h0005;
    req_in.ready = 1'b1;
    req_in.valid = 1'b1;
    @(posedge clk); #1;
    req_in.valid = 1'b0;
    total++;
    if (req_accept !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_accept: acc=%b want 1", req_accept);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (req_accept !== 1'b0 || rsp_out !== '0 || txn_count !== 8'd0) begin
      bad++;
      $display("FAIL rstmid_outputs: acc=%b rsp=%h cnt=%0d want 0/0/0", req_accept, rsp_out, txn_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 16'h0005, 32'h0, 1, 1'b0, acc, rsp, st, va, cnt);
    model_txn(1'b0, 16'h0005, 32'h0, exp);
    total++;
    if (acc !== 1'b1 || rsp !== exp || rsp.data !== 32'h0 || cnt !== 8'd1) begin
      bad++;
      $display("FAIL rstmid_read5: acc=%b rsp=%h cnt=%0d want 1 %h 1", acc, rsp, cnt, exp);
    end
  endtask

  task automatic test_wrap();
    bus_transaction_t rsp, exp;
    logic acc, st, va, wr;
    logic [7:0] cnt;
    logic [7:0] start;
    logic [15:0] a;
    logic [31:0] d;
    start = 8'(mcnt);
    for (int n = 0; n < 256; n++) begin
      wr = 1'($urandom);
      a  = 16'($urandom_range(0, 31));
      d  = $urandom;
      xact(wr, a, d, 0, 1'b0, acc, rsp, st, va, cnt);
      model_txn(wr, a, d, exp);
      total++;
      if (rsp !== exp || cnt !== 8'(mcnt)) begin
        bad++;
        $display("FAIL wrap_%0d: rsp=%h cnt=%0d want %h %0d", n, rsp, cnt, exp, mcnt);
      end
    end
    total++;
    if (txn_count !== start) begin
      bad++;
      $display("FAIL wrap_final: cnt=%0d want %0d", txn_count, start);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_miss();
    test_random();
    test_backpressure();
    test_ignore_taken();
    test_throughput();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
